bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector FSMs. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `sout`. That bit stream drives the detector's `in` input directly. A one-word holding register keeps consecutive words gapless on the serial side.

---
 rtl/bit_serializer.sv | 114 +++++++++++
 tb/tb_bit_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register for gapless back-to-back frames.
// Define SER_PARITY_EN to append an even-parity bit to every frame (FRAME = WIDTH+1).
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int            CW   = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_sout;
  logic             r_sout_valid;

  logic             w_accept;
  logic             w_free;
  logic [WIDTH-1:0] w_load_word;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_sh_adv;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_next_bit;

  assign w_accept    = din_valid & ~r_hold_full;
  // The last bit is still on the wire during the edge that starts the next frame.
  assign w_free      = (r_state == S_IDLE) | (r_cnt == LAST);
  assign w_load_word = r_hold_full ? r_hold : din;
  assign w_load_bit  = MSB_FIRST ? w_load_word[WIDTH-1] : w_load_word[0];
  assign w_sh_adv    = MSB_FIRST ? (r_sh << 1) : (r_sh >> 1);
  assign w_cnt_inc   = r_cnt + CW'(1);

`ifdef SER_PARITY_EN
  localparam logic [CW-1:0] PAR_POS = CW'(WIDTH);
  logic r_par;

  assign w_next_bit = (w_cnt_inc == PAR_POS) ? r_par
                    : (MSB_FIRST ? w_sh_adv[WIDTH-1] : w_sh_adv[0]);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)
      r_par <= 1'b0;
    else if (w_free && (r_hold_full || w_accept))
      r_par <= ^w_load_word;
  end
`else
  assign w_next_bit = MSB_FIRST ? w_sh_adv[WIDTH-1] : w_sh_adv[0];
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the data registers are reset too, so nothing from an aborted frame survives reset.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
    end else if (w_free) begin
      if (r_hold_full || w_accept) begin
        r_state      <= S_SHIFT;
        r_sout_valid <= 1'b1;
        r_cnt        <= '0;
        r_sh         <= w_load_word;
        r_sout       <= w_load_bit;
        if (r_hold_full) begin
          if (w_accept)
            r_hold <= din;
          else
            r_hold_full <= 1'b0;
        end
      end else begin
        r_state      <= S_IDLE;
        r_sout_valid <= 1'b0;
        r_sout       <= 1'b0;
        r_cnt        <= '0;
      end
    end else begin
      r_cnt  <= w_cnt_inc;
      r_sh   <= w_sh_adv;
      r_sout <= w_next_bit;
      if (w_accept) begin
        r_hold      <= din;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign din_ready  = ~r_hold_full;
  assign busy       = (r_state == S_SHIFT) | r_hold_full;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are compared
// every cycle against a frame-level queue model, plus literal frame expectations.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FRAME = W + 1;
  localparam logic [63:0] L_A5  = 64'b101001010;
  localparam logic [63:0] L_07  = 64'b000001111;
  localparam logic [63:0] L_01L = 64'b100000001;
  localparam logic [63:0] L_B2B = 64'b111111110_000000000_111100000;
  localparam logic [63:0] L_21  = 64'b001000010;
  localparam logic [63:0] L_3C  = 64'b001111000;
`else
  localparam int FRAME = W;
  localparam logic [63:0] L_A5  = 64'b10100101;
  localparam logic [63:0] L_07  = 64'b00000111;
  localparam logic [63:0] L_01L = 64'b10000000;
  localparam logic [63:0] L_B2B = 64'hFF00F0;
  localparam logic [63:0] L_21  = 64'b00100001;
  localparam logic [63:0] L_3C  = 64'b00111100;
`endif

  logic         clk = 1'b0;
  logic         nRESET;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy_m, sout_m, sv_m, busy_m;
  logic         rdy_l, sout_l, sv_l, busy_l;

  int n_chk = 0;
  int n_err = 0;

  bit cap_m[$];
  bit cap_l[$];
  int cyc_m[$];
  int cyc      = 0;
  int stall_cnt = 0;

  logic [W-1:0] m_cur = '0;
  int           m_pos = -1;
  logic [W-1:0] m_hq[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .nRESET(nRESET), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .nRESET(nRESET), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .busy(busy_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame bit `pos` of word w: data bits in shift order, then parity at position W.
  function automatic logic exp_bit(input logic [W-1:0] w, input int pos, input bit msb);
    if (pos == W) return ^w;
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  // Model: a current frame (word + bit position) and a pending-word queue of depth one.
  initial begin
    forever begin
      @(posedge clk or negedge nRESET);
      if (!nRESET) begin
        m_pos = -1;
        m_cur = '0;
        m_hq.delete();
      end else begin
        bit acc;
        acc = din_valid && (m_hq.size() == 0);
        if (m_pos < 0 || m_pos == FRAME - 1) begin
          if (m_hq.size() > 0) begin
            m_cur = m_hq.pop_front();
            m_pos = 0;
            if (acc) m_hq.push_back(din);
          end else if (acc) begin
            m_cur = din;
            m_pos = 0;
          end else begin
            m_pos = -1;
          end
        end else begin
          m_pos++;
          if (acc) m_hq.push_back(din);
        end
      end
    end
  end

  // Compare and capture process.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("sout_valid_m", sv_m, m_pos >= 0);
      check("sout_valid_l", sv_l, m_pos >= 0);
      check("sout_m", sout_m, (m_pos >= 0) ? exp_bit(m_cur, m_pos, 1'b1) : 1'b0);
      check("sout_l", sout_l, (m_pos >= 0) ? exp_bit(m_cur, m_pos, 1'b0) : 1'b0);
      check("din_ready_m", rdy_m, m_hq.size() == 0);
      check("din_ready_l", rdy_l, m_hq.size() == 0);
      check("busy_m", busy_m, (m_pos >= 0) || (m_hq.size() != 0));
      check("busy_l", busy_l, (m_pos >= 0) || (m_hq.size() != 0));
      if (sv_m) begin
        cap_m.push_back(sout_m);
        cyc_m.push_back(cyc);
      end
      if (sv_l) cap_l.push_back(sout_l);
      if (din_valid && !rdy_m) stall_cnt++;
    end
  end

  task automatic check_cap(input string name, input bit lsb, input logic [63:0] lit,
                           input int n, input int start);
    int got;
    got = (lsb ? cap_l.size() : cap_m.size()) - start;
    check({name, " len"}, got, n);
    for (int i = 0; i < n && i < got; i++)
      check($sformatf("%s bit%0d", name, i), lsb ? cap_l[start+i] : cap_m[start+i], lit[n-1-i]);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_word(input logic [W-1:0] w, input bit keep);
    int n;
    n = 0;
    din       = w;
    din_valid = 1'b1;
    while (!rdy_m && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept wait", rdy_m, 1'b1);
    @(posedge clk); #1;
    if (!keep) din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_m || busy_l) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain busy", busy_m | busy_l, 1'b0);
    check("drain sout_valid", sv_m | sv_l, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int st_stall;
    nRESET    = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset sout_valid", sv_m, 1'b0);
    check("reset sout", sout_m, 1'b0);
    check("reset din_ready", rdy_m, 1'b1);
    check("reset busy", busy_m, 1'b0);
    nRESET = 1'b1;
    @(posedge clk); #1;

    st = cap_m.size();
    send_word(8'hA5, 1'b0);
    wait_idle();
    check_cap("A5 msb", 1'b0, L_A5, FRAME, st);

    st = cap_m.size();
    send_word(8'h07, 1'b0);
    wait_idle();
    check_cap("07 msb", 1'b0, L_07, FRAME, st);

    st = cap_l.size();
    send_word(8'h01, 1'b0);
    wait_idle();
    check_cap("01 lsb", 1'b1, L_01L, FRAME, st);

    st       = cap_m.size();
    st_stall = stall_cnt;
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    send_word(8'hF0, 1'b0);
    wait_idle();
    check_cap("b2b", 1'b0, L_B2B, 3 * FRAME, st);
    if (cyc_m.size() >= st + 3 * FRAME)
      check("b2b contiguous", cyc_m[st + 3*FRAME - 1] - cyc_m[st], 3 * FRAME - 1);
    check("b2b ready drop", stall_cnt > st_stall, 1'b1);

    st = cap_m.size();
    send_word(8'h21, 1'b0);
    wait_idle();
    check_cap("21 detector stream", 1'b0, L_21, FRAME, st);

    // Abort mid-frame at bit 3 with the holding register full.
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    din = 8'h81;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-abort ready", rdy_m, 1'b0);
    check("pre-abort busy", busy_m, 1'b1);
    #1;
    nRESET    = 1'b0;
    din_valid = 1'b0;
    #1;
    check("abort sout_valid", sv_m, 1'b0);
    check("abort sout", sout_m, 1'b0);
    check("abort busy", busy_m, 1'b0);
    check("abort din_ready", rdy_m, 1'b1);
    @(posedge clk); #1;
    nRESET = 1'b1;
    @(posedge clk); #1;
    st = cap_m.size();
    send_word(8'h3C, 1'b0);
    wait_idle();
    check_cap("3C after abort", 1'b0, L_3C, FRAME, st);

    for (int c = 0; c < 600; c++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 99) < ((c < 300) ? 85 : 30));
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
